// File: rtl/coef_update_scheduler_pkg.sv
// Shared constants, FSM state type and word-select helper for the coefficient
// update scheduler.
package coef_pkg;

   localparam int COEF_W         = 16;
   localparam int NUM_BANDS      = 3;
   localparam int COEFS_PER_BAND = 5;
   localparam int NUM_COEFS      = NUM_BANDS * COEFS_PER_BAND;
   localparam int SET_W          = COEF_W * NUM_COEFS;
   localparam int IDX_W          = 4;

   // Word index = band*5 + k, k ordered b0, b1, b2, a1, a2.
   localparam logic [IDX_W-1:0] LOW_B0  = 4'd0,  LOW_B1  = 4'd1,  LOW_B2  = 4'd2,  LOW_A1  = 4'd3,  LOW_A2  = 4'd4;
   localparam logic [IDX_W-1:0] MID_B0  = 4'd5,  MID_B1  = 4'd6,  MID_B2  = 4'd7,  MID_A1  = 4'd8,  MID_A2  = 4'd9;
   localparam logic [IDX_W-1:0] HIGH_B0 = 4'd10, HIGH_B1 = 4'd11, HIGH_B2 = 4'd12, HIGH_A1 = 4'd13, HIGH_A2 = 4'd14;

   typedef enum logic [1:0] {
      ST_IDLE        = 2'd0,
      ST_WRITE       = 2'd1,
      ST_COMMIT_WAIT = 2'd2
   } state_t;

   // Word 0 (low_b0) occupies the most significant slice of the packed set.
   function automatic logic [COEF_W-1:0] word_sel(input logic [SET_W-1:0] set,
                                                 input logic [IDX_W-1:0] idx);
      logic [SET_W-1:0] sh;
      sh = set >> (COEF_W * (NUM_COEFS - 1 - int'(idx)));
      return sh[COEF_W-1:0];
   endfunction

endpackage

// File: rtl/coef_update_scheduler.sv
// Captures a received coefficient set, streams it into the cascade's shadow
// bank around filter reads, and commits it on an audio sample boundary.
module coef_update_scheduler
   import coef_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic [SET_W-1:0]  coef_in,
   input  logic              valid_in,
   input  logic              sample_tick,
   input  logic              filt_busy,
   output logic              wr_en,
   output logic [IDX_W-1:0]  wr_addr,
   output logic [COEF_W-1:0] wr_data,
   output logic              commit,
   output logic              busy,
   output logic              overrun,
   output logic [7:0]        update_count,
   output state_t            state_dbg
);

   // Handshake: valid_in is a one-cycle pulse qualifying coef_in in that cycle;
   // there is no ready, so a set arriving while busy parks in pending (last wins).

   state_t             state_q, state_d;
   logic [SET_W-1:0]   shadow_q, shadow_d;
   logic [SET_W-1:0]   pending_q, pending_d;
   logic               pend_flag_q, pend_flag_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               commit_q, commit_d;
   logic               overrun_q, overrun_d;
   logic [7:0]         count_q, count_d;
   logic               capture_pend;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         shadow_q    <= '0;
         pending_q   <= '0;
         pend_flag_q <= 1'b0;
         idx_q       <= '0;
         commit_q    <= 1'b0;
         overrun_q   <= 1'b0;
         count_q     <= '0;
      end else begin
         state_q     <= state_d;
         shadow_q    <= shadow_d;
         pending_q   <= pending_d;
         pend_flag_q <= pend_flag_d;
         idx_q       <= idx_d;
         commit_q    <= commit_d;
         overrun_q   <= overrun_d;
         count_q     <= count_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      shadow_d     = shadow_q;
      pending_d    = pending_q;
      pend_flag_d  = pend_flag_q;
      idx_d        = idx_q;
      commit_d     = 1'b0;
      overrun_d    = overrun_q;
      count_d      = count_q;
      capture_pend = 1'b0;
      wr_en        = 1'b0;
      wr_addr      = '0;
      wr_data      = '0;

      unique case (state_q)
         ST_IDLE: begin
            if (valid_in) begin
               shadow_d = coef_in;
               idx_d    = '0;
               state_d  = ST_WRITE;
            end
         end
         ST_WRITE: begin
            wr_en   = !filt_busy;
            wr_addr = idx_q;
            wr_data = word_sel(shadow_q, idx_q);
            if (wr_en) begin
               if (idx_q == HIGH_A2) state_d = ST_COMMIT_WAIT;
               else                  idx_d   = idx_q + 1'b1;
            end
            capture_pend = valid_in;
         end
         ST_COMMIT_WAIT: begin
            if (sample_tick) begin
               commit_d = 1'b1;
               count_d  = count_q + 1'b1;
               idx_d    = '0;
               // A fresh set on the tick edge supersedes anything parked.
               if (valid_in) begin
                  shadow_d    = coef_in;
                  pend_flag_d = 1'b0;
                  state_d     = ST_WRITE;
               end else if (pend_flag_q) begin
                  shadow_d    = pending_q;
                  pend_flag_d = 1'b0;
                  state_d     = ST_WRITE;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               capture_pend = valid_in;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (capture_pend) begin
         pending_d   = coef_in;
         pend_flag_d = 1'b1;
         if (pend_flag_q) overrun_d = 1'b1;
      end
   end

   assign commit       = commit_q;
   assign busy         = (state_q != ST_IDLE);
   assign overrun      = overrun_q;
   assign update_count = count_q;
   assign state_dbg    = state_q;

endmodule

// File: tb/tb_coef_update_scheduler.sv
// Self-checking bench for coef_update_scheduler: table-driven load rows plus
// hand-written sequences for tick/pending/reset corner cases.
module tb_coef_update_scheduler;
   import coef_pkg::*;

   localparam int LOG_N = 128;

   logic              clk;
   logic              reset;
   logic [SET_W-1:0]  coef_in;
   logic              valid_in;
   logic              sample_tick;
   logic              filt_busy;
   logic              wr_en;
   logic [IDX_W-1:0]  wr_addr;
   logic [COEF_W-1:0] wr_data;
   logic              commit;
   logic              busy;
   logic              overrun;
   logic [7:0]        update_count;
   state_t            state_dbg;

   coef_update_scheduler dut (
      .clk          (clk),
      .reset        (reset),
      .coef_in      (coef_in),
      .valid_in     (valid_in),
      .sample_tick  (sample_tick),
      .filt_busy    (filt_busy),
      .wr_en        (wr_en),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data),
      .commit       (commit),
      .busy         (busy),
      .overrun      (overrun),
      .update_count (update_count),
      .state_dbg    (state_dbg)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- scoreboard state ----------------
   logic [IDX_W+COEF_W-1:0] exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc;
   int   n_commits;
   int   last_wr;
   int   addr2_cyc;
   int   exp_count = 0;
   logic busy_log   [LOG_N];
   logic commit_log [LOG_N];
   logic wren_log   [LOG_N];
   logic [IDX_W-1:0] addr_log [LOG_N];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [SET_W-1:0] make_inc(input logic [15:0] base);
      logic [SET_W-1:0] s;
      s = '0;
      for (int i = 0; i < NUM_COEFS; i++) s[(NUM_COEFS-1-i)*COEF_W +: COEF_W] = base + 16'(i);
      return s;
   endfunction

   task automatic push_set(input logic [SET_W-1:0] s, input int n);
      for (int i = 0; i < n; i++) exp_q.push_back({4'(i), s[(NUM_COEFS-1-i)*COEF_W +: COEF_W]});
   endtask

   task automatic start_seq();
      cyc       = 0;
      n_commits = 0;
      last_wr   = -1;
      addr2_cyc = -1;
      for (int i = 0; i < LOG_N; i++) begin
         busy_log[i] = 1'b0; commit_log[i] = 1'b0; wren_log[i] = 1'b0; addr_log[i] = '0;
      end
   endtask

   // Drives inputs sampled at the next edge, applies fb for the following cycle,
   // then samples outputs at the falling edge.
   task automatic run_cycle(input logic v, input logic [SET_W-1:0] set, input logic tk,
                            input logic fb, input logic rst_n);
      logic [IDX_W+COEF_W-1:0] e;
      valid_in    = v;
      coef_in     = set;
      sample_tick = tk;
      reset       = rst_n;
      @(posedge clk);
      cyc++;
      #1;
      valid_in    = 1'b0;
      sample_tick = 1'b0;
      reset       = 1'b1;
      filt_busy   = fb;
      @(negedge clk);
      if (cyc < LOG_N) begin
         busy_log[cyc] = busy; commit_log[cyc] = commit; wren_log[cyc] = wr_en; addr_log[cyc] = wr_addr;
      end
      if (fb) check("stall_no_write", 32'(wr_en), 32'd0);
      if (wr_en) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_write: got addr %0d data %0h, expected no write (cycle %0d)",
                     wr_addr, wr_data, cyc);
         end else begin
            e = exp_q.pop_front();
            check("wr_word", 32'({wr_addr, wr_data}), 32'(e));
         end
         last_wr = cyc;
         if (wr_addr == 4'd2) addr2_cyc = cyc;
      end
      if (commit) n_commits++;
   endtask

   typedef struct {
      logic [15:0] base;
      int tick_c;
      int stall_lo;
      int stall_hi;
      int last_c;
      int addr2_c;
      int commit_c;
   } vec_t;

   vec_t rows[4];

   initial begin
      logic [SET_W-1:0] sa, sb, sc, sd;

      rows[0] = '{16'h1000, 20,  0, -1, 15,  3, 21};
      rows[1] = '{16'h2000, 25,  3,  6, 19,  7, 26};
      rows[2] = '{16'hFFF0, 16,  0, -1, 15,  3, 17};
      rows[3] = '{16'h8000, 17,  1,  1, 16,  4, 18};

      reset = 1'b0; coef_in = '0; valid_in = 1'b0; sample_tick = 1'b0; filt_busy = 1'b0;
      start_seq();
      for (int i = 0; i < 3; i++) run_cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
      check("rst_wr_en",   32'(wr_en), 0);
      check("rst_wr_addr", 32'(wr_addr), 0);
      check("rst_wr_data", 32'(wr_data), 0);
      check("rst_commit",  32'(commit), 0);
      check("rst_busy",    32'(busy), 0);
      check("rst_overrun", 32'(overrun), 0);
      check("rst_count",   32'(update_count), 0);
      check("rst_state",   32'(state_dbg), 32'(ST_IDLE));

      // Table rows: one set each, optional stall window, one tick.
      for (int r = 0; r < 4; r++) begin
         start_seq();
         sa = make_inc(rows[r].base);
         push_set(sa, NUM_COEFS);
         for (int e = 0; e <= rows[r].commit_c; e++)
            run_cycle(e == 0, sa, e == rows[r].tick_c,
                      (e + 1 >= rows[r].stall_lo) && (e + 1 <= rows[r].stall_hi), 1'b1);
         exp_count++;
         check("row_commits",     32'(n_commits), 1);
         check("row_commit_cyc",  32'(commit_log[rows[r].commit_c]), 1);
         check("row_busy_wait",   32'(busy_log[rows[r].tick_c]), 1);
         check("row_busy_fall",   32'(busy_log[rows[r].commit_c]), 0);
         check("row_last_write",  last_wr, rows[r].last_c);
         check("row_addr2_cyc",   addr2_cyc, rows[r].addr2_c);
         check("row_count",       32'(update_count), exp_count);
         check("row_sb_empty",    exp_q.size(), 0);
         check("row_overrun",     32'(overrun), 0);
      end

      // Tick coincident with the final write is ignored.
      start_seq();
      sa = make_inc(16'h3000);
      push_set(sa, NUM_COEFS);
      for (int e = 0; e <= 41; e++) run_cycle(e == 0, sa, (e == 15) || (e == 40), 1'b0, 1'b1);
      exp_count++;
      check("lastw_tick_commits", 32'(n_commits), 1);
      check("lastw_tick_no16",    32'(commit_log[16]), 0);
      check("lastw_tick_c41",     32'(commit_log[41]), 1);
      check("lastw_tick_count",   32'(update_count), exp_count);

      // New set on the commit tick restarts WRITE immediately.
      start_seq();
      sa = make_inc(16'h4000);
      sd = make_inc(16'h5000);
      push_set(sa, NUM_COEFS);
      push_set(sd, NUM_COEFS);
      for (int e = 0; e <= 39; e++)
         run_cycle((e == 0) || (e == 20), (e == 20) ? sd : sa, (e == 20) || (e == 38), 1'b0, 1'b1);
      exp_count += 2;
      check("vtick_commit21",  32'(commit_log[21]), 1);
      check("vtick_wr21",      32'(wren_log[21]), 1);
      check("vtick_addr21",    32'(addr_log[21]), 0);
      check("vtick_busy21",    32'(busy_log[21]), 1);
      check("vtick_commit39",  32'(commit_log[39]), 1);
      check("vtick_commits",   32'(n_commits), 2);
      check("vtick_last_wr",   last_wr, 35);
      check("vtick_overrun",   32'(overrun), 0);
      check("vtick_count",     32'(update_count), exp_count);
      check("vtick_sb_empty",  exp_q.size(), 0);

      // Random data with random stalls early in the stream.
      start_seq();
      for (int i = 0; i < NUM_COEFS; i++) sa[i*COEF_W +: COEF_W] = 16'($urandom_range(0, 65535));
      push_set(sa, NUM_COEFS);
      for (int e = 0; e <= 60; e++)
         run_cycle(e == 0, sa, e == 60, (e + 1 <= 30) && ($urandom_range(0, 3) == 0), 1'b1);
      exp_count++;
      check("rand_commit61",  32'(commit_log[61]), 1);
      check("rand_commits",   32'(n_commits), 1);
      check("rand_sb_empty",  exp_q.size(), 0);
      check("rand_count",     32'(update_count), exp_count);

      // A, then B and C during A's write: C wins, B never written.
      start_seq();
      sa = make_inc(16'h6000);
      sb = make_inc(16'h7000);
      sc = make_inc(16'h8800);
      push_set(sa, NUM_COEFS);
      push_set(sc, NUM_COEFS);
      for (int e = 0; e <= 37; e++)
         run_cycle((e == 0) || (e == 5) || (e == 9), (e == 5) ? sb : ((e == 9) ? sc : sa),
                   (e == 18) || (e == 36), 1'b0, 1'b1);
      exp_count += 2;
      check("pend_commit19",  32'(commit_log[19]), 1);
      check("pend_commit37",  32'(commit_log[37]), 1);
      check("pend_commits",   32'(n_commits), 2);
      check("pend_last_wr",   last_wr, 33);
      check("pend_overrun",   32'(overrun), 1);
      check("pend_count",     32'(update_count), exp_count);
      check("pend_sb_empty",  exp_q.size(), 0);

      // Reset during the addr-7 write abandons the set.
      start_seq();
      sa = make_inc(16'h9000);
      push_set(sa, 8);
      for (int e = 0; e <= 31; e++) run_cycle(e == 0, sa, (e == 20) || (e == 30), 1'b0, !(e == 8));
      check("rstmid_last_wr",  last_wr, 8);
      check("rstmid_wr9",      32'(wren_log[9]), 0);
      check("rstmid_busy9",    32'(busy_log[9]), 0);
      check("rstmid_commits",  32'(n_commits), 0);
      check("rstmid_count",    32'(update_count), 0);
      check("rstmid_overrun",  32'(overrun), 0);
      check("rstmid_wr_addr",  32'(wr_addr), 0);
      check("rstmid_wr_data",  32'(wr_data), 0);
      check("rstmid_busy",     32'(busy), 0);
      check("rstmid_sb_empty", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/coef_update_scheduler.md
# coef_update_scheduler

Sequences delivery of a received biquad coefficient set into the three-band filter cascade. It sits between the SPI receive path, which produces a 240-bit coefficient set plus a one-cycle valid pulse, and the cascade's coefficient bus, which is a shadow-bank write port plus a bank-swap commit. It captures a set, streams the 15 words over a shared write port when the filter is not busy, and commits only on an audio sample boundary, so no sample is ever computed with a mixed coefficient set.

## Interface
- COEF_W, 16, coefficient width (signed Q-format, passed through unmodified)
- NUM_BANDS, 3, filter bands (low, mid, high)
- COEFS_PER_BAND, 5, coefficients per band (b0, b1, b2, a1, a2)
- clk  in  1  system clock
- reset  in  1  synchronous, active-low
- coef_in  in  240  packed set; low_b0 in bits [239:224], then low_b1..low_a2, mid_b0..mid_a2, high_b0..high_a2; high_a2 in bits [15:0]
- valid_in  in  1  one-cycle pulse; coef_in is valid in that cycle
- sample_tick  in  1  one-cycle pulse at each audio sample start
- filt_busy  in  1  cascade is reading coefficients; the write port must stall
- wr_en  out  1  shadow-bank write strobe
- wr_addr  out  4  word index 0..14, equal to band*5+k, with k ordered b0, b1, b2, a1, a2
- wr_data  out  16  coefficient word for wr_addr
- commit  out  1  one-cycle bank-swap pulse
- busy  out  1  high in any state except IDLE
- overrun  out  1  sticky; a pending set was overwritten before it was serviced
- update_count  out  8  number of commits, wraps 255 to 0

## Operation
- States:
  - IDLE: busy=0.
  - WRITE: streaming the 15 words.
  - COMMIT_WAIT: all words written, waiting for a sample boundary.
- Registers:
  - shadow[239:0]: set being written.
  - pending[239:0] and pending_flag: set received while busy.
  - idx[3:0]: current word index.
- IDLE, valid_in=1: shadow<=coef_in, idx<=0, go to WRITE.
- WRITE:
  - wr_en = !filt_busy, wr_addr = idx, wr_data = shadow word idx. These outputs are combinational from the registers.
  - idx increments only when wr_en=1.
  - When wr_en=1 with idx=14, go to COMMIT_WAIT.
  - filt_busy=1 holds idx and writes nothing; no timeout.
- COMMIT_WAIT, sample_tick=1 at a clock edge:
  - commit<=1 for exactly one cycle (registered).
  - update_count<=update_count+1.
  - If valid_in=1 on that edge, shadow<=coef_in, pending_flag<=0, go to WRITE with idx=0.
  - Else if pending_flag=1, shadow<=pending, pending_flag<=0, go to WRITE.
  - Else go to IDLE.
- valid_in in WRITE, or in COMMIT_WAIT without a tick:
  - pending<=coef_in, pending_flag<=1.
  - If pending_flag was already 1, overrun<=1. Last set wins.
- The active set is never modified mid-write. Writes target only the shadow bank; commit is the only bank-swap event.
- Sets are not merged or validated; values pass through bit-exact.

## Timing
- Reset values:
  - State IDLE; shadow, pending, idx all 0; pending_flag 0.
  - Outputs: wr_en 0, wr_addr 0, wr_data 0, commit 0, busy 0, overrun 0, update_count 0.
- Reset mid-operation (WRITE or COMMIT_WAIT) abandons the set. No commit is issued, and the cascade keeps its old active bank.
- Latency with filt_busy=0:
  - valid_in at edge 0: writes in cycles 1..15 (addr 0..14), COMMIT_WAIT from cycle 16.
  - First tick sampled at edge T≥16: commit high in cycle T+1.
- A sample_tick coincident with the last write (state still WRITE) is ignored; commit waits for the next tick.
- Each filt_busy cycle delays the remaining writes by one cycle.
- valid_in and sample_tick are single-cycle pulses. A multi-cycle valid_in is treated as repeated sets, with last-wins and overrun rules applied.

## Structure
- Package coef_pkg: COEF_W, NUM_BANDS, COEFS_PER_BAND, NUM_COEFS=15, the word-index constants for b0..a2 per band, and the state enum type.
- Word select (shadow slice by idx): a function in coef_pkg.
- No sub-module is required. The block is a single FSM with its registers.

## Test plan
- Basic load: set with word i = 16'h1000+i; valid_in; tick at cycle 20 -> wr_addr 0..14 with data 16'h1000..16'h100E in cycles 1..15, commit in cycle 21, update_count=1, busy falls in cycle 21.
- Stall: filt_busy=1 in cycles 3..6 -> no wr_en in those cycles; addr 2 written in cycle 7; last write in cycle 19; data sequence unchanged.
- Tick during last write: tick coincident with the addr-14 write -> no commit; next tick at cycle 40 -> commit in cycle 41.
- Pending and overrun: sets A, B, C with B and C arriving during A's write -> A committed, then C written and committed; B never appears on wr_data; overrun=1; update_count=2.
- valid_in coincident with the commit tick: set D -> commit pulses, WRITE restarts immediately with D word 0 in the next cycle, overrun stays 0.
- Reset mid-WRITE at addr 7: reset low one cycle -> all outputs 0, no commit on subsequent ticks, update_count=0.
